// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving an analog sample/DAC/comparator macro.
// Optional 4-sample averaging is enabled by defining SAR_AVG4_EN.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CH_BITS       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               start,
    input  logic [CH_BITS-1:0] chan,
    input  logic               cmp_in,
    output logic [CH_BITS-1:0] mux_sel,
    output logic               sample_hold,
    output logic [WIDTH-1:0]   dac_code,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic             cmp_m, cmp_s;
    logic             sample_end, bit_end, last_bit, conv_last;
    logic [WIDTH-1:0] final_code, trial_code;

`ifdef SAR_AVG4_EN
    logic [1:0]       conv;
    logic [WIDTH+1:0] acc, acc_sum;
    assign conv_last = (conv == 2'd3);
    assign acc_sum   = acc + (WIDTH+2)'(final_code);
`else
    assign conv_last = 1'b1;
`endif

    assign sample_end = (cnt == CW'(SAMPLE_CYCLES - 1));
    assign bit_end    = (cnt == CW'(SETTLE_CYCLES - 1));
    assign last_bit   = (idx == '0);

    // Resolve the bit under trial, then pre-set the next lower bit.
    always_comb begin
        final_code      = dac_code;
        final_code[idx] = cmp_s;
        trial_code      = final_code | (WIDTH'(1) << (idx - IW'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (!ena) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_n = SAMPLE;
                SAMPLE:  if (sample_end) state_n = TRIAL;
                TRIAL:   if (bit_end && last_bit) state_n = conv_last ? DONE : SAMPLE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = 1'b0;
        sample_hold = 1'b0;
        done        = 1'b0;
        unique case (state)
            SAMPLE:  begin busy = 1'b1; sample_hold = 1'b1; end
            TRIAL:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_m <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            cmp_m <= cmp_in;
            cmp_s <= cmp_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            mux_sel  <= '0;
            dac_code <= '0;
            result   <= '0;
`ifdef SAR_AVG4_EN
            conv     <= '0;
            acc      <= '0;
`endif
        end else if (!ena) begin
            cnt <= '0;
`ifdef SAR_AVG4_EN
            acc <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    mux_sel  <= chan;
                    dac_code <= '0;
                    cnt      <= '0;
`ifdef SAR_AVG4_EN
                    conv     <= '0;
                    acc      <= '0;
`endif
                end
                SAMPLE: begin
                    cnt <= cnt + CW'(1);
                    if (sample_end) begin
                        cnt      <= '0;
                        idx      <= IW'(WIDTH - 1);
                        dac_code <= WIDTH'(1) << (WIDTH - 1);
                    end
                end
                TRIAL: begin
                    cnt <= cnt + CW'(1);
                    if (bit_end) begin
                        cnt <= '0;
                        if (!last_bit) begin
                            dac_code <= trial_code;
                            idx      <= idx - IW'(1);
                        end else begin
                            dac_code <= final_code;
`ifdef SAR_AVG4_EN
                            if (conv_last) begin
                                result <= WIDTH'(acc_sum >> 2);
                            end else begin
                                acc      <= acc_sum;
                                conv     <= conv + 2'd1;
                                dac_code <= '0;
                            end
`else
                            result <= final_code;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed self-checking bench for sar_adc_ctrl with a behavioural comparator.
// Cycle 1 is the cycle right after the edge that accepts start.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst, ena, start, cmp_in;
    logic [1:0] chan, mux_sel;
    logic       sample_hold, busy, done;
    logic [7:0] dac_code, result;
    logic [7:0] vin;

    int passed = 0;
    int total  = 0;

    int done_cyc, sh_cnt, ndone, nrise;
    logic [7:0] trace [8];
    logic [7:0] vseq  [4];
    bit   use_seq;

`ifdef SAR_AVG4_EN
    localparam int LAT = 137;
`else
    localparam int LAT = 35;
`endif

    sar_adc_ctrl dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .chan(chan),
        .cmp_in(cmp_in), .mux_sel(mux_sel), .sample_hold(sample_hold),
        .dac_code(dac_code), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    assign cmp_in = (vin >= dac_code);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_conv(input logic [7:0] v, input logic [1:0] ch, input bit restart);
        logic sh_prev;
        int   cyc;
        vin = v; chan = ch; start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1; done_cyc = 0; sh_cnt = 0; ndone = 0; nrise = 0; sh_prev = 1'b0;
        while (cyc <= LAT + 25) begin
            if (sample_hold) sh_cnt++;
            if (sample_hold && !sh_prev) begin
                if (use_seq && nrise < 4) vin = vseq[nrise];
                nrise++;
            end
            sh_prev = sample_hold;
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc >= 3 && cyc <= 31 && (cyc - 3) % 4 == 0) trace[(cyc - 3) / 4] = dac_code;
            start = restart && (cyc == 5 || cyc == 20);
            tick;
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a5 [8];
        logic [7:0] exp_ff [8];
        exp_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        exp_ff = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        use_seq = 1'b0;
        rst = 1'b1; ena = 1'b1; start = 1'b0; chan = '0; vin = '0;
        tick; tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sh", sample_hold, 0);
        check("rst_dac", dac_code, 0);
        check("rst_mux", mux_sel, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        tick;

        ena = 1'b0; start = 1'b1; chan = 2'd3;
        tick;
        start = 1'b0;
        check("start_no_ena", busy, 0);
        ena = 1'b1;
        tick;

        run_conv(8'hA5, 2'd2, 1'b0);
        check("a5_lat", done_cyc, LAT);
        check("a5_ndone", ndone, 1);
        check("a5_result", result, 8'hA5);
        check("a5_mux", mux_sel, 2);
        check("a5_sh", sh_cnt, 2 * (LAT - 1) / 34);
        for (int i = 0; i < 8; i++) check($sformatf("a5_trial%0d", i), trace[i], exp_a5[i]);

        run_conv(8'h00, 2'd1, 1'b0);
        check("zero_result", result, 8'h00);
        check("zero_trial0", trace[0], 8'h80);
        check("zero_trial1", trace[1], 8'h40);
        check("zero_trial7", trace[7], 8'h01);

        run_conv(8'hFF, 2'd3, 1'b0);
        check("ff_result", result, 8'hFF);
        check("ff_mux", mux_sel, 3);
        for (int i = 0; i < 8; i++) check($sformatf("ff_trial%0d", i), trace[i], exp_ff[i]);

        run_conv(8'h5A, 2'd0, 1'b1);
        check("busy_start_ndone", ndone, 1);
        check("busy_start_lat", done_cyc, LAT);
        check("busy_start_result", result, 8'h5A);

        run_conv(8'hA5, 2'd2, 1'b0);
        check("a5b_result", result, 8'hA5);

        vin = 8'h33; chan = 2'd1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick;
        check("pre_abort_busy", busy, 1);
        ena = 1'b0;
        tick;
        check("abort_busy", busy, 0);
        check("abort_sh", sample_hold, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            tick;
        end
        check("abort_ndone", ndone, 0);
        check("abort_result", result, 8'hA5);
        ena = 1'b1;
        tick;
        run_conv(8'h6B, 2'd1, 1'b0);
        check("post_abort_result", result, 8'h6B);
        check("post_abort_lat", done_cyc, LAT);

        vin = 8'h77; chan = 2'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick;
        check("pre_rst_dac_nz", dac_code != 0, 1);
        rst = 1'b1;
        tick;
        check("mrst_busy", busy, 0);
        check("mrst_sh", sample_hold, 0);
        check("mrst_done", done, 0);
        check("mrst_dac", dac_code, 0);
        check("mrst_mux", mux_sel, 0);
        check("mrst_result", result, 0);
        rst = 1'b0;
        tick;
        run_conv(8'h3C, 2'd2, 1'b0);
        check("post_rst_result", result, 8'h3C);

`ifdef SAR_AVG4_EN
        vseq = '{8'h10, 8'h11, 8'h12, 8'h14};
        use_seq = 1'b1;
        run_conv(8'h10, 2'd1, 1'b0);
        use_seq = 1'b0;
        check("avg_ndone", ndone, 1);
        check("avg_lat", done_cyc, 137);
        check("avg_result", result, 8'h11);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
